// File: rtl/fft_acc_ram_reader_pkg.sv
// fft_acc_rd_pkg: shared types and constants for the FFT accelerator RAM reader.
//   - rd_state_e : reader FSM states (IDLE, READ, DRAIN)
//   - RAM_DEPTH  : word depth of the on-chip RAM slave (also the max transfer length)
//   - DEF_*      : default widths used by the reader, its buffer and its interface
package fft_acc_rd_pkg;

  localparam int RAM_DEPTH     = 8192;
  localparam int DEF_ADDR_W    = 13;
  localparam int DEF_DATA_W    = 32;
  localparam int DEF_CNT_W     = 14;
  localparam int DEF_BUF_DEPTH = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } rd_state_e;

endpackage

// File: rtl/fft_acc_ram_reader_if.sv
// fft_acc_ram_reader_if: bus bundle between the RAM reader, the RAM slave and the
// FFT datapath consumer.
//   Avalon-MM read side : m_address, m_chipselect, m_write, m_byteenable, m_clken,
//                         m_readdata (1-cycle read latency, no waitrequest)
//   Stream side         : out_data, out_valid, out_last, out_ready
// Modports:
//   master - the reader (drives the RAM request and the stream)
//   slave  - the RAM/consumer environment (returns read data and ready)
interface fft_acc_ram_reader_if
  import fft_acc_rd_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);

  logic [ADDR_W-1:0] m_address;
  logic              m_chipselect;
  logic              m_write;
  logic [3:0]        m_byteenable;
  logic              m_clken;
  logic [DATA_W-1:0] m_readdata;

  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_last;
  logic              out_ready;

  modport master (
    output m_address, m_chipselect, m_write, m_byteenable, m_clken,
    input  m_readdata,
    output out_data, out_valid, out_last,
    input  out_ready
  );

  modport slave (
    input  m_address, m_chipselect, m_write, m_byteenable, m_clken,
    output m_readdata,
    input  out_data, out_valid, out_last,
    output out_ready
  );

endinterface

// File: rtl/fft_acc_rd_buf.sv
// fft_acc_rd_buf: small first-word-fall-through FIFO holding RAM read data until
// the stream consumer accepts it.
//   clk, reset  : clock, asynchronous active-high reset (pointers/occupancy only)
//   push        : read data arriving this cycle (push_data valid)
//   pop         : head word accepted this cycle (only asserted while head_valid)
//   head_data   : current head word; the arriving word is forwarded when empty,
//                 and 0 when nothing is available
//   head_valid  : a word is available (stored, or arriving this cycle)
//   occupancy   : number of stored entries, excluding a word arriving this cycle
module fft_acc_rd_buf
  import fft_acc_rd_pkg::*;
#(
  parameter  int DATA_W    = DEF_DATA_W,
  parameter  int BUF_DEPTH = DEF_BUF_DEPTH,
  localparam int PTR_W     = $clog2(BUF_DEPTH),
  localparam int OCC_W     = PTR_W + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head_data,
  output logic              head_valid,
  output logic [OCC_W-1:0]  occupancy
);

  logic [DATA_W-1:0] mem [BUF_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [OCC_W-1:0]  occ;
  logic              empty;
  logic              store_wr;
  logic              store_rd;

  assign empty = (occ == '0);
  // An arriving word consumed in the same cycle while empty bypasses storage.
  assign store_wr = push && !(empty && pop);
  assign store_rd = pop && !empty;

  assign head_valid = !empty || push;
  assign occupancy  = occ;

  always_comb begin
    head_data = '0;
    if (!empty) begin
      head_data = mem[rd_ptr];
    end else if (push) begin
      head_data = push_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (store_wr) wr_ptr <= wr_ptr + PTR_W'(1);
      if (store_rd) rd_ptr <= rd_ptr + PTR_W'(1);
      occ <= occ + OCC_W'(store_wr) - OCC_W'(store_rd);
    end
  end

  always_ff @(posedge clk) begin
    if (store_wr) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/fft_acc_ram_reader.sv
// fft_acc_ram_reader: Avalon-MM read master that fetches a contiguous block of
// words from the FFT accelerator's on-chip RAM and streams them to the datapath.
//   clk, reset  : clock, asynchronous active-high reset
//   start       : command strobe, ignored while busy
//   base_addr   : first word address (sampled with start)
//   word_count  : words to read (sampled with start, saturated to RAM depth)
//   busy        : transfer in progress
//   done        : one-cycle pulse after the final word is accepted
//   bus         : fft_acc_ram_reader_if.master (RAM read port + output stream)
// Optional: define FFT_ACC_RD_CSUM_EN to add output csum, the modulo-2^DATA_W sum
// of the words streamed out in the current transfer (cleared on accepted start).
module fft_acc_ram_reader
  import fft_acc_rd_pkg::*;
#(
  parameter  int ADDR_W    = DEF_ADDR_W,
  parameter  int DATA_W    = DEF_DATA_W,
  parameter  int CNT_W     = DEF_CNT_W,
  parameter  int BUF_DEPTH = DEF_BUF_DEPTH,
  localparam int OCC_W     = $clog2(BUF_DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  word_count,
  output logic              busy,
  output logic              done,
`ifdef FFT_ACC_RD_CSUM_EN
  output logic [DATA_W-1:0] csum,
`endif
  fft_acc_ram_reader_if.master bus
);

  function automatic logic [CNT_W-1:0] sat_count(input logic [CNT_W-1:0] cnt);
    if ({1'b0, cnt} > (CNT_W+1)'(RAM_DEPTH)) return CNT_W'(RAM_DEPTH);
    return cnt;
  endfunction

  rd_state_e         state;
  rd_state_e         state_nxt;
  logic [ADDR_W-1:0] rd_addr;
  logic [CNT_W-1:0]  remaining;
  logic [CNT_W-1:0]  words_left;
  logic [CNT_W-1:0]  cnt_sat;
  logic              cs_p1;
  logic              accept;
  logic              issue;
  logic              pop;
  logic              last_pop;
  logic              head_valid;
  logic [DATA_W-1:0] head_data;
  logic [OCC_W-1:0]  occ;
  logic [OCC_W:0]    pending;

  assign cnt_sat  = sat_count(word_count);
  assign accept   = start && (state == IDLE);
  // Words already committed to the buffer: stored ones plus the read in flight.
  assign pending  = {1'b0, occ} + (OCC_W+1)'(cs_p1);
  assign pop      = head_valid && bus.out_ready;
  assign last_pop = pop && (words_left == CNT_W'(1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept && (cnt_sat != '0)) state_nxt = READ;
      READ:    if (issue && (remaining == CNT_W'(1))) state_nxt = DRAIN;
      DRAIN:   if (last_pop) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy  = (state != IDLE);
    issue = (state == READ) && (remaining != '0) &&
            (pending < (OCC_W+1)'(BUF_DEPTH));
  end

  // Request stage: address/count bookkeeping; cs_p1 marks data returning next cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_addr    <= '0;
      remaining  <= '0;
      words_left <= '0;
      cs_p1      <= 1'b0;
      done       <= 1'b0;
    end else begin
      cs_p1 <= issue;
      done  <= (accept && (cnt_sat == '0)) || last_pop;
      if (accept) begin
        rd_addr    <= base_addr;
        remaining  <= cnt_sat;
        words_left <= cnt_sat;
      end else begin
        if (issue) begin
          rd_addr   <= rd_addr + ADDR_W'(1);
          remaining <= remaining - CNT_W'(1);
        end
        if (pop) words_left <= words_left - CNT_W'(1);
      end
    end
  end

  // Capture stage: read data lands in the buffer the cycle after its request.
  fft_acc_rd_buf #(
    .DATA_W    (DATA_W),
    .BUF_DEPTH (BUF_DEPTH)
  ) u_buf (
    .clk        (clk),
    .reset      (reset),
    .push       (cs_p1),
    .push_data  (bus.m_readdata),
    .pop        (pop),
    .head_data  (head_data),
    .head_valid (head_valid),
    .occupancy  (occ)
  );

  assign bus.m_address    = rd_addr;
  assign bus.m_chipselect = issue;
  assign bus.m_write      = 1'b0;
  assign bus.m_byteenable = 4'hF;
  assign bus.m_clken      = 1'b1;
  assign bus.out_data     = head_data;
  assign bus.out_valid    = head_valid;
  assign bus.out_last     = head_valid && (words_left == CNT_W'(1));

`ifdef FFT_ACC_RD_CSUM_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)       csum <= '0;
    else if (accept) csum <= '0;
    else if (pop)    csum <= csum + head_data;
  end
`endif

endmodule

// File: tb/tb_fft_acc_ram_reader.sv
// tb_fft_acc_ram_reader: randomized scoreboard bench for fft_acc_ram_reader.
// A behavioural RAM answers reads one cycle after chipselect; each transfer's
// expected read addresses and stream words are queued from the RAM contents, and
// a negedge monitor pops and compares whenever the DUT reads or hands off a word.
module tb_fft_acc_ram_reader;
  import fft_acc_rd_pkg::*;

  localparam int ADDR_W    = 13;
  localparam int DATA_W    = 32;
  localparam int CNT_W     = 14;
  localparam int BUF_DEPTH = 2;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic [CNT_W-1:0]  word_count = '0;
  logic              busy;
  logic              done;
`ifdef FFT_ACC_RD_CSUM_EN
  logic [DATA_W-1:0] csum;
`endif

  fft_acc_ram_reader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  fft_acc_ram_reader #(
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .CNT_W     (CNT_W),
    .BUF_DEPTH (BUF_DEPTH)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .base_addr  (base_addr),
    .word_count (word_count),
    .busy       (busy),
    .done       (done),
`ifdef FFT_ACC_RD_CSUM_EN
    .csum       (csum),
`endif
    .bus        (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural RAM: garbage on the data bus except the cycle after a read.
  logic [DATA_W-1:0] ram [0:RAM_DEPTH-1];
  always @(posedge clk) begin
    if (bus.m_chipselect) bus.m_readdata <= ram[bus.m_address];
    else                  bus.m_readdata <= $urandom;
  end

  int rdy_mode = 0;
  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       bus.out_ready = 1'b1;
        1:       bus.out_ready = ~bus.out_ready;
        default: bus.out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  logic [ADDR_W-1:0] q_addr [$];
  logic [DATA_W-1:0] q_data [$];
  logic              q_last [$];
  int                n_issued = 0;
  int                n_popped = 0;
  int                last_hs_cyc = 0;
  logic              prev_stall = 1'b0;
  logic [DATA_W-1:0] prev_data = '0;

  always @(negedge clk) begin
    if (reset) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid_held", 64'(bus.out_valid), 64'd1);
        check("stall_data_held", 64'(bus.out_data), 64'(prev_data));
      end
      if (n_issued != n_popped)
        check("occupancy_bound", 64'((n_issued - n_popped) <= BUF_DEPTH), 64'd1);
      if (bus.m_chipselect) begin
        check("read_expected", 64'(q_addr.size() != 0), 64'd1);
        if (q_addr.size() != 0) check("read_addr", 64'(bus.m_address), 64'(q_addr.pop_front()));
        n_issued++;
      end
      if (bus.out_valid && bus.out_ready) begin
        check("word_expected", 64'(q_data.size() != 0), 64'd1);
        if (q_data.size() != 0) begin
          check("word_data", 64'(bus.out_data), 64'(q_data.pop_front()));
          check("word_last", 64'(bus.out_last), 64'(q_last.pop_front()));
        end
        n_popped++;
        last_hs_cyc = cyc;
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_data  = bus.out_data;
    end
  end

  task automatic enqueue(input int base, input int n, output logic [DATA_W-1:0] sum);
    int a;
    sum = '0;
    for (int i = 0; i < n; i++) begin
      a = (base + i) % RAM_DEPTH;
      q_addr.push_back(ADDR_W'(a));
      q_data.push_back(ram[a]);
      q_last.push_back(i == n - 1);
      sum = sum + ram[a];
    end
  endtask

  task automatic flush_queues();
    q_addr.delete();
    q_data.delete();
    q_last.delete();
    n_issued = 0;
    n_popped = 0;
  endtask

  // Called aligned at posedge+1 with the DUT idle; returns aligned the same way.
  task automatic run_xfer(input int base, input int cnt, input int mode, input bit poke);
    int n;
    bit got;
    logic [DATA_W-1:0] sum;
    n = (cnt > RAM_DEPTH) ? RAM_DEPTH : cnt;
    rdy_mode = mode;
    flush_queues();
    enqueue(base, n, sum);
    base_addr  = ADDR_W'(base);
    word_count = CNT_W'(cnt);
    start      = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    if (n == 0) begin
      check("zero_done", 64'(done), 64'd1);
      check("zero_busy", 64'(busy), 64'd0);
      @(negedge clk);
      check("zero_done_pulse", 64'(done), 64'd0);
      check("zero_busy_after", 64'(busy), 64'd0);
    end else begin
      check("busy_after_start", 64'(busy), 64'd1);
      check("first_cs", 64'(bus.m_chipselect), 64'd1);
      check("first_addr", 64'(bus.m_address), 64'(base % RAM_DEPTH));
      @(negedge clk);
      check("first_valid", 64'(bus.out_valid), 64'd1);
      if (poke) begin
        @(posedge clk);
        #1;
        check("busy_at_poke", 64'(busy), 64'd1);
        base_addr  = 13'h1234;
        word_count = 14'd5;
        start      = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
      end
      got = 1'b0;
      for (int k = 0; k < 4 * n + 50; k++) begin
        @(negedge clk);
        if (done) begin
          got = 1'b1;
          break;
        end
      end
      check("done_seen", 64'(got), 64'd1);
      if (got) begin
        check("done_latency", 64'(cyc), 64'(last_hs_cyc + 1));
        check("busy_low_with_done", 64'(busy), 64'd0);
`ifdef FFT_ACC_RD_CSUM_EN
        check("csum_model", 64'(csum), 64'(sum));
`endif
      end
      check("all_words_out", 64'(q_data.size()), 64'd0);
      check("all_reads_out", 64'(q_addr.size()), 64'd0);
    end
    @(posedge clk);
    #1;
    flush_queues();
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_done"}, 64'(done), 64'd0);
    check({tag, "_cs"}, 64'(bus.m_chipselect), 64'd0);
    check({tag, "_addr"}, 64'(bus.m_address), 64'd0);
    check({tag, "_valid"}, 64'(bus.out_valid), 64'd0);
    check({tag, "_last"}, 64'(bus.out_last), 64'd0);
    check({tag, "_data"}, 64'(bus.out_data), 64'd0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DATA_W-1:0] dummy;
    bit hit;
    for (int i = 0; i < RAM_DEPTH; i++) ram[i] = $urandom;
    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    check("reset_write", 64'(bus.m_write), 64'd0);
    check("reset_byteen", 64'(bus.m_byteenable), 64'hF);
    check("reset_clken", 64'(bus.m_clken), 64'd1);
    reset = 1'b0;
    @(posedge clk);
    #1;

    run_xfer(32'h0010, 4, 0, 1'b0);
    run_xfer(32'h1FFE, 4, 0, 1'b0);
    run_xfer(32'h0100, 8, 1, 1'b1);
    run_xfer(32'h0200, 0, 0, 1'b0);

    // Reset while the third of eight words is on the stream.
    rdy_mode = 0;
    flush_queues();
    enqueue(32'h0040, 8, dummy);
    base_addr  = 13'h0040;
    word_count = 14'd8;
    start      = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    hit = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(posedge clk);
      if (n_popped >= 2) begin
        hit = 1'b1;
        break;
      end
    end
    check("mid_reset_reached", 64'(hit), 64'd1);
    #2;
    reset = 1'b1;
    #1;
    check_idle_outputs("midreset");
    flush_queues();
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    run_xfer(0, 2, 0, 1'b0);

    for (int r = 0; r < 6; r++)
      run_xfer(int'($urandom_range(0, RAM_DEPTH - 1)), int'($urandom_range(1, 40)),
               int'($urandom_range(0, 2)), 1'b0);

    run_xfer(32'h0300, 9000, 0, 1'b0);

`ifdef FFT_ACC_RD_CSUM_EN
    ram[0] = 32'h0000_0001;
    ram[1] = 32'h0000_0002;
    ram[2] = 32'h0000_0003;
    ram[3] = 32'hFFFF_FFFF;
    run_xfer(0, 4, 0, 1'b0);
    check("csum_wrap", 64'(csum), 64'h5);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
